gpio_bank: RTL and testbench

Parametrised GPIO controller: the next generation of the SoC's 2-pin GPIO slave. It serves up to 16 pins behind the same RIB slave port (we/wraddr/wdata/rdata). Each pin has a 2-flop input synchroniser, optional debounce, and edge-triggered interrupts with a write-1-to-clear pending register. Pad tristating stays in the SoC top: the block drives `gpio_o`/`gpio_oe` and samples `gpio_i`.

---
 rtl/gpio_bank_pkg.sv | 43 ++++
 rtl/gpio_in_cond.sv | 74 +++++++
 rtl/gpio_bank.sv | 175 +++++++++++++++++
 tb/tb_gpio_bank.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the gpio_bank slice: register word offsets,
// pin mode and edge-select encodings, and the edge-match helper.
package gpio_bank_pkg;

    // Register word offsets, decoded from wraddr[4:2]
    localparam logic [2:0] GPIO_CTRL_OFS = 3'd0;
    localparam logic [2:0] GPIO_DATA_OFS = 3'd1;
    localparam logic [2:0] GPIO_EDGE_OFS = 3'd2;
    localparam logic [2:0] GPIO_PEND_OFS = 3'd3;
    localparam logic [2:0] GPIO_DBNC_OFS = 3'd4;

    // Per-pin mode held in CTRL
    typedef enum logic [1:0] {
        GPIO_MODE_OFF = 2'b00,
        GPIO_MODE_OUT = 2'b01,
        GPIO_MODE_IN  = 2'b10,
        GPIO_MODE_IRQ = 2'b11
    } gpio_mode_e;

    // Per-pin edge select held in EDGE
    typedef enum logic [1:0] {
        GPIO_EDGE_NONE = 2'b00,
        GPIO_EDGE_RISE = 2'b01,
        GPIO_EDGE_FALL = 2'b10,
        GPIO_EDGE_BOTH = 2'b11
    } gpio_edge_e;

    // True when the observed transition matches the selected edge type
    function automatic logic edge_hit(input logic [1:0] edge_sel,
                                      input logic       rise,
                                      input logic       fall);
        logic hit_s;
        case (gpio_edge_e'(edge_sel))
            GPIO_EDGE_NONE: hit_s = 1'b0;
            GPIO_EDGE_RISE: hit_s = rise;
            GPIO_EDGE_FALL: hit_s = fall;
            GPIO_EDGE_BOTH: hit_s = rise | fall;
            default:        hit_s = 1'b0;
        endcase
        return hit_s;
    endfunction

endpackage

// File: rtl/gpio_in_cond.sv
// Per-pin input conditioning: 2-flop synchroniser, optional debounce
// (built only when GPIO_DEBOUNCE_EN is defined), prev flop and
// rise/fall detection on the conditioned value.
module gpio_in_cond
    import gpio_bank_pkg::*;
#(
    parameter int DBNC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pin_raw,
    input  logic [DBNC_W-1:0] dbnc,
    output logic              cond,
    output logic              rise,
    output logic              fall
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic cond_s;

    // Two-flop synchroniser for the asynchronous pad input
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pin_raw;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic              cond_r;
    logic [DBNC_W-1:0] cnt_r;

    // Debounce: sync2 must disagree with cond for dbnc+1 cycles before cond follows
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_r <= 1'b0;
            cnt_r  <= '0;
        end else if (sync2_r == cond_r) begin
            cnt_r  <= '0;
        end else if (cnt_r == dbnc) begin
            cond_r <= sync2_r;
            cnt_r  <= '0;
        end else begin
            cnt_r  <= cnt_r + DBNC_W'(1);
        end
    end

    assign cond_s = cond_r;
`else
    logic unused_dbnc_s;

    assign cond_s        = sync2_r;
    assign unused_dbnc_s = ^dbnc;
`endif

    // Previous conditioned value, tracked in every mode
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= cond_s;
        end
    end

    assign cond = cond_s;
    assign rise = cond_s & ~prev_r;
    assign fall = ~cond_s & prev_r;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO controller behind the RIB slave port.
// Registers CTRL/DATA/EDGE/PEND/DBNC, edge interrupts with W1C pending bits.
// Optional per-pin debounce is enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int GPIO_NUM = 2,
    parameter int DBNC_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [31:0]         wraddr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    input  logic [GPIO_NUM-1:0] gpio_i,
    output logic [GPIO_NUM-1:0] gpio_o,
    output logic [GPIO_NUM-1:0] gpio_oe,
    output logic                irq
);

    localparam int CW = 2 * GPIO_NUM;

    logic [CW-1:0]       ctrl_r;
    logic [CW-1:0]       ctrl_nxt_s;
    logic [CW-1:0]       edge_sel_r;
    logic [GPIO_NUM-1:0] out_r;
    logic [GPIO_NUM-1:0] oe_r;
    logic [GPIO_NUM-1:0] oe_nxt_s;
    logic [GPIO_NUM-1:0] pend_r;
    logic [GPIO_NUM-1:0] pend_nxt_s;
    logic [GPIO_NUM-1:0] pend_set_s;
    logic [GPIO_NUM-1:0] pend_clr_s;
    logic [GPIO_NUM-1:0] irq_en_s;
    logic [GPIO_NUM-1:0] cond_s;
    logic [GPIO_NUM-1:0] rise_s;
    logic [GPIO_NUM-1:0] fall_s;
    logic                irq_r;
    logic                irq_nxt_s;
    logic [DBNC_W-1:0]   dbnc_s;
    logic [31:0]         rdata_s;
    logic [2:0]          ofs_s;
    logic                wr_ctrl_s;
    logic                wr_data_s;
    logic                wr_edge_s;
    logic                wr_pend_s;
    logic                unused_s;

    assign ofs_s     = wraddr[4:2];
    assign wr_ctrl_s = we && (ofs_s == GPIO_CTRL_OFS);
    assign wr_data_s = we && (ofs_s == GPIO_DATA_OFS);
    assign wr_edge_s = we && (ofs_s == GPIO_EDGE_OFS);
    assign wr_pend_s = we && (ofs_s == GPIO_PEND_OFS);

    // Address bits above/below the word index are decoded by the interconnect
    assign unused_s = ^{wraddr[31:5], wraddr[1:0], wdata};

`ifdef GPIO_DEBOUNCE_EN
    logic [DBNC_W-1:0] dbnc_r;

    // Debounce threshold register
    always_ff @(posedge clk) begin
        if (rst) begin
            dbnc_r <= '0;
        end else if (we && (ofs_s == GPIO_DBNC_OFS)) begin
            dbnc_r <= wdata[DBNC_W-1:0];
        end else begin
            dbnc_r <= dbnc_r;
        end
    end

    assign dbnc_s = dbnc_r;
`else
    assign dbnc_s = '0;
`endif

    // One conditioning lane per pin
    for (genvar k = 0; k < GPIO_NUM; k++) begin : g_pin
        gpio_in_cond #(
            .DBNC_W (DBNC_W)
        ) u_in_cond (
            .clk     (clk),
            .rst     (rst),
            .pin_raw (gpio_i[k]),
            .dbnc    (dbnc_s),
            .cond    (cond_s[k]),
            .rise    (rise_s[k]),
            .fall    (fall_s[k])
        );
    end

    // Next-state for CTRL, PEND and the registered oe/irq outputs
    always_comb begin
        ctrl_nxt_s = ctrl_r;
        pend_clr_s = '0;
        pend_set_s = '0;
        oe_nxt_s   = '0;
        irq_en_s   = '0;
        if (wr_ctrl_s) begin
            ctrl_nxt_s = wdata[CW-1:0];
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
        if (wr_pend_s) begin
            pend_clr_s = wdata[GPIO_NUM-1:0];
        end else begin
            pend_clr_s = '0;
        end
        for (int k = 0; k < GPIO_NUM; k++) begin
            pend_set_s[k] = (gpio_mode_e'(ctrl_r[2*k +: 2]) == GPIO_MODE_IRQ) &&
                            edge_hit(edge_sel_r[2*k +: 2], rise_s[k], fall_s[k]);
            oe_nxt_s[k]   = (gpio_mode_e'(ctrl_nxt_s[2*k +: 2]) == GPIO_MODE_OUT);
            irq_en_s[k]   = (gpio_mode_e'(ctrl_nxt_s[2*k +: 2]) == GPIO_MODE_IRQ);
        end
        // A new edge beats a concurrent W1C of the same bit
        pend_nxt_s = (pend_r & ~pend_clr_s) | pend_set_s;
        irq_nxt_s  = |(pend_nxt_s & irq_en_s);
    end

    // Register file and registered pad/interrupt outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r     <= '0;
            edge_sel_r <= '0;
            out_r      <= '0;
            pend_r     <= '0;
            oe_r       <= '0;
            irq_r      <= 1'b0;
        end else begin
            ctrl_r     <= ctrl_nxt_s;
            pend_r     <= pend_nxt_s;
            oe_r       <= oe_nxt_s;
            irq_r      <= irq_nxt_s;
            if (wr_edge_s) begin
                edge_sel_r <= wdata[CW-1:0];
            end else begin
                edge_sel_r <= edge_sel_r;
            end
            if (wr_data_s) begin
                out_r <= wdata[GPIO_NUM-1:0];
            end else begin
                out_r <= out_r;
            end
        end
    end

    // Zero-wait-state read mux on the current (pre-edge) register state
    always_comb begin
        rdata_s = '0;
        case (ofs_s)
            GPIO_CTRL_OFS: rdata_s = 32'(ctrl_r);
            GPIO_DATA_OFS: begin
                for (int k = 0; k < GPIO_NUM; k++) begin
                    case (gpio_mode_e'(ctrl_r[2*k +: 2]))
                        GPIO_MODE_OFF: rdata_s[k] = 1'b0;
                        GPIO_MODE_OUT: rdata_s[k] = out_r[k];
                        GPIO_MODE_IN:  rdata_s[k] = cond_s[k];
                        GPIO_MODE_IRQ: rdata_s[k] = cond_s[k];
                        default:       rdata_s[k] = 1'b0;
                    endcase
                end
            end
            GPIO_EDGE_OFS: rdata_s = 32'(edge_sel_r);
            GPIO_PEND_OFS: rdata_s = 32'(pend_r);
            GPIO_DBNC_OFS: rdata_s = 32'(dbnc_s);
            default:       rdata_s = '0;
        endcase
    end

    assign rdata   = rdata_s;
    assign gpio_o  = out_r;
    assign gpio_oe = oe_r;
    assign irq     = irq_r;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (GPIO_NUM = 2).
// Expected values are hand-computed from the register map and input latency.
module tb_gpio_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [31:0] wraddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  gpio_i;
    logic [1:0]  gpio_o;
    logic [1:0]  gpio_oe;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    gpio_bank #(
        .GPIO_NUM (2),
        .DBNC_W   (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .wraddr  (wraddr),
        .wdata   (wdata),
        .rdata   (rdata),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Debounce with threshold 0 still adds one cycle of latency
    task automatic dbnc_tick();
`ifdef GPIO_DEBOUNCE_EN
        tick();
`endif
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we     = 1'b1;
        wraddr = a;
        wdata  = d;
        tick();
        we     = 1'b0;
        wdata  = 32'h0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we     = 1'b0;
        wraddr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    initial begin
        logic [31:0] offs [6];
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C};

        rst    = 1'b1;
        we     = 1'b0;
        wraddr = 32'h0;
        wdata  = 32'h0;
        gpio_i = 2'b00;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_gpio_o", 32'(gpio_o), 32'h0);
        check("rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 6; i++) begin
            chk_rd($sformatf("rst_rd_%0h", offs[i]), offs[i], 32'h0);
        end

        // Output mode on pin 0, pin 1 stays hi-Z
        wr(32'h00, 32'h1);
        check("out_oe", 32'(gpio_oe), 32'h1);
        wr(32'h04, 32'h1);
        check("out_o", 32'(gpio_o), 32'h1);
        chk_rd("out_rd_data", 32'h04, 32'h1);
        wr(32'h04, 32'h3);
        check("out_o_all", 32'(gpio_o), 32'h3);
        chk_rd("out_rd_data_masked", 32'h04, 32'h1);

        // Concurrent write: read still shows pre-edge DATA
        we = 1'b1; wraddr = 32'h00; wdata = 32'h0; #1;
        check("rd_pre_edge", rdata, 32'h1);
        we = 1'b0;
        tick();

        // Input mode on pin 1
        wr(32'h00, 32'h8);
        check("in_oe", 32'(gpio_oe), 32'h0);
        gpio_i = 2'b10;
        tick();
        chk_rd("in_data_e0", 32'h04, 32'h0);
        tick();
        dbnc_tick();
        chk_rd("in_data_e1", 32'h04, 32'h2);
        wr(32'h00, 32'h0);
        chk_rd("off_data", 32'h04, 32'h0);

        gpio_i = 2'b00;
        repeat (6) tick();

        // Rising-edge interrupt on pin 0
        wr(32'h08, 32'h1);
        wr(32'h00, 32'h3);
        gpio_i = 2'b01;
        tick();
        tick();
        dbnc_tick();
        chk_rd("rise_pend_e1", 32'h0C, 32'h0);
        check("rise_irq_e1", 32'(irq), 32'h0);
        tick();
        chk_rd("rise_pend_e2", 32'h0C, 32'h1);
        check("rise_irq_e2", 32'(irq), 32'h1);
        chk_rd("rise_data", 32'h04, 32'h1);
        wr(32'h0C, 32'h1);
        chk_rd("w1c_pend", 32'h0C, 32'h0);
        check("w1c_irq", 32'(irq), 32'h0);

        // Falling edge is not selected
        gpio_i = 2'b00;
        repeat (5) tick();
        chk_rd("fall_pend", 32'h0C, 32'h0);
        check("fall_irq", 32'(irq), 32'h0);

        // Set and clear of the same bit in one cycle: set wins
        gpio_i = 2'b01;
        tick();
        tick();
        dbnc_tick();
        wr(32'h0C, 32'h1);
        chk_rd("race_pend", 32'h0C, 32'h1);
        check("race_irq", 32'(irq), 32'h1);

        // Leaving IRQ mode keeps PEND but masks irq
        wr(32'h00, 32'h2);
        check("mask_irq", 32'(irq), 32'h0);
        chk_rd("mask_pend", 32'h0C, 32'h1);
        wr(32'h00, 32'h3);
        check("unmask_irq", 32'(irq), 32'h1);
        wr(32'h0C, 32'h3);
        check("clr_irq", 32'(irq), 32'h0);

        // Upper write bits ignored; pin 1 both-edges interrupt
        wr(32'h08, 32'hFFFF_FFFD);
        chk_rd("edge_rd", 32'h08, 32'hD);
        wr(32'h00, 32'hFFFF_FFFF);
        chk_rd("ctrl_rd", 32'h00, 32'hF);
        gpio_i = 2'b11;
        repeat (3) tick();
        dbnc_tick();
        chk_rd("both_rise_pend", 32'h0C, 32'h2);
        check("both_rise_irq", 32'(irq), 32'h1);
        wr(32'h0C, 32'h2);
        gpio_i = 2'b01;
        repeat (3) tick();
        dbnc_tick();
        chk_rd("both_fall_pend", 32'h0C, 32'h2);
        wr(32'h0C, 32'h0);
        chk_rd("w1c_zero_pend", 32'h0C, 32'h2);

        // Unmapped offset and DBNC register
        wr(32'h1C, 32'hFFFF_FFFF);
        chk_rd("unmapped_rd", 32'h1C, 32'h0);
        chk_rd("unmapped_ctrl", 32'h00, 32'hF);
        wr(32'h10, 32'h3);
`ifdef GPIO_DEBOUNCE_EN
        chk_rd("dbnc_rd", 32'h10, 32'h3);

        // Glitch shorter than DBNC+1 cycles is filtered
        gpio_i = 2'b00;
        repeat (12) tick();
        wr(32'h0C, 32'h3);
        gpio_i = 2'b01;
        repeat (3) tick();
        gpio_i = 2'b00;
        repeat (10) tick();
        chk_rd("glitch_pend", 32'h0C, 32'h0);
        chk_rd("glitch_data", 32'h04, 32'h0);

        // Stable level passes 4 cycles after sync2
        gpio_i = 2'b01;
        repeat (5) tick();
        chk_rd("level_data_e4", 32'h04, 32'h0);
        tick();
        chk_rd("level_data_e5", 32'h04, 32'h1);
        chk_rd("level_pend_e5", 32'h0C, 32'h0);
        tick();
        chk_rd("level_pend_e6", 32'h0C, 32'h1);
`else
        chk_rd("dbnc_rd", 32'h10, 32'h0);
`endif

        // Reset mid-operation
        wr(32'h00, 32'hD);
        wr(32'h04, 32'h3);
        check("pre_rst_oe", 32'(gpio_oe), 32'h1);
        check("pre_rst_o", 32'(gpio_o), 32'h3);
        gpio_i = 2'b10;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_gpio_o", 32'(gpio_o), 32'h0);
        check("mid_rst_gpio_oe", 32'(gpio_oe), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_rd($sformatf("mid_rst_rd_%0h", offs[i]), offs[i], 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
